// File: rtl/instr_mem_loader.sv
// Byte-stream loader that writes a length-prefixed bytecode image into instruction memory as {instr, arg} words.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before reporting completion.
module instr_mem_loader #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         START_LOAD,
  input  logic [DATA_WIDTH-1:0]        BYTE_IN,
  input  logic                         BYTE_VALID,
  output logic                         BYTE_READY,
  output logic                         MEM_WR_EN,
  output logic [ADDR_WIDTH-1:0]        MEM_WR_ADDR,
  output logic [INSTRUCTION_WIDTH-1:0] MEM_WR_DATA,
  output logic                         LOAD_BUSY,
  output logic                         LOAD_DONE,
  output logic                         LOAD_ERROR,
  output logic [ADDR_WIDTH:0]          WORDS_LOADED
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_INSTR,
    S_ARG,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_accept;
  logic                      w_start;
  logic [2*DATA_WIDTH-1:0]   w_len;
  logic [ADDR_WIDTH:0]       w_words_inc;
  logic                      w_last_word;
  logic [DATA_WIDTH-1:0]     r_len_hi;
  logic [2*DATA_WIDTH-1:0]   r_len;
  logic [DATA_WIDTH-1:0]     r_instr;
  logic                      r_wr_en;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic [INSTRUCTION_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH:0]       r_words;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]     r_csum;
`endif

  assign w_accept    = BYTE_VALID && BYTE_READY;
  assign w_start     = START_LOAD && !LOAD_BUSY;
  assign w_len       = {r_len_hi, BYTE_IN};
  assign w_words_inc = r_words + 1'b1;
  assign w_last_word = (32'(w_words_inc) == 32'(r_len));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (START_LOAD) w_state_nxt = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (32'(w_len) > MAX_WORDS)
            w_state_nxt = S_ERR;
          else if (w_len == '0)
`ifdef INSTR_LOADER_CHECKSUM_EN
            w_state_nxt = S_CHK;
`else
            w_state_nxt = S_DONE;
`endif
          else
            w_state_nxt = S_INSTR;
        end
      end
      S_INSTR: if (w_accept) w_state_nxt = S_ARG;
      S_ARG: begin
        if (w_accept) begin
          if (w_last_word)
`ifdef INSTR_LOADER_CHECKSUM_EN
            w_state_nxt = S_CHK;
`else
            w_state_nxt = S_DONE;
`endif
          else
            w_state_nxt = S_INSTR;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: if (w_accept) w_state_nxt = (BYTE_IN == r_csum) ? S_DONE : S_ERR;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    BYTE_READY = 1'b0;
    LOAD_BUSY  = 1'b1;
    LOAD_DONE  = 1'b0;
    LOAD_ERROR = 1'b0;
    case (r_state)
      S_IDLE:  LOAD_BUSY = 1'b0;
      S_DONE: begin
        LOAD_BUSY = 1'b0;
        LOAD_DONE = 1'b1;
      end
      S_ERR: begin
        LOAD_BUSY  = 1'b0;
        LOAD_ERROR = 1'b1;
      end
      S_LEN_HI, S_LEN_LO, S_INSTR, S_ARG: BYTE_READY = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: BYTE_READY = 1'b1;
`endif
      default: LOAD_BUSY = 1'b0;
    endcase
  end

  // Datapath: header/instr capture, word write and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_hi  <= '0;
      r_len     <= '0;
      r_instr   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_words   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_words <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        r_csum  <= '0;
`endif
      end
      if (w_accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ BYTE_IN;
`endif
        case (r_state)
          S_LEN_HI: r_len_hi <= BYTE_IN;
          S_LEN_LO: r_len    <= w_len;
          S_INSTR:  r_instr  <= BYTE_IN;
          S_ARG: begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_words[ADDR_WIDTH-1:0];
            r_wr_data <= {r_instr, BYTE_IN};
            r_words   <= w_words_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign MEM_WR_EN    = r_wr_en;
  assign MEM_WR_ADDR  = r_wr_addr;
  assign MEM_WR_DATA  = r_wr_data;
  assign WORDS_LOADED = r_words;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a queue-based image model.
// Follows INSTR_LOADER_CHECKSUM_EN to decide whether a checksum byte is appended.
module tb_instr_mem_loader;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        START_LOAD = 1'b0;
  logic [7:0]  BYTE_IN = '0;
  logic        BYTE_VALID = 1'b0;
  logic        BYTE_READY;
  logic        MEM_WR_EN;
  logic [11:0] MEM_WR_ADDR;
  logic [15:0] MEM_WR_DATA;
  logic        LOAD_BUSY;
  logic        LOAD_DONE;
  logic        LOAD_ERROR;
  logic [12:0] WORDS_LOADED;

  instr_mem_loader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(12),
    .INSTRUCTION_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .START_LOAD(START_LOAD),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .MEM_WR_EN(MEM_WR_EN), .MEM_WR_ADDR(MEM_WR_ADDR), .MEM_WR_DATA(MEM_WR_DATA),
    .LOAD_BUSY(LOAD_BUSY), .LOAD_DONE(LOAD_DONE), .LOAD_ERROR(LOAD_ERROR),
    .WORDS_LOADED(WORDS_LOADED)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [27:0] q_exp[$];      // expected writes: {addr, data}
  logic [15:0] img[$];        // caller-supplied words; remainder randomized
  bit          full_image;    // last expected write completes the image

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write monitor: every write must be the next one the model predicts
  always @(negedge clk) begin
    if (!rst && MEM_WR_EN) begin
      if (q_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_write: got addr 0x%0h data 0x%0h expected no write", MEM_WR_ADDR, MEM_WR_DATA);
      end else begin
        logic [27:0] e;
        e = q_exp.pop_front();
        chk("wr_addr", MEM_WR_ADDR, e[27:16]);
        chk("wr_data", MEM_WR_DATA, e[15:0]);
        chk("words_at_wr", WORDS_LOADED, e[27:16] + 1);
        if (q_exp.size() == 0 && full_image)
          chk("done_with_last_wr", LOAD_DONE, CHK_EN ? 0 : 1);
      end
    end
  end

  task automatic pulse_start();
    START_LOAD = 1'b1;
    @(posedge clk); #1;
    START_LOAD = 1'b0;
  endtask

  // Present one byte after 0..gapmax idle cycles; START_LOAD noise during gaps must be ignored
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n;
    bit got;
    repeat ($urandom_range(0, gapmax)) begin
      BYTE_VALID = 1'b0;
      BYTE_IN    = 8'($urandom);
      START_LOAD = 1'($urandom);
      @(posedge clk); #1;
    end
    START_LOAD = 1'b0;
    BYTE_VALID = 1'b1;
    BYTE_IN    = b;
    n = 0;
    do begin
      got = BYTE_READY;
      @(posedge clk); #1;
      n++;
    end while (!got && n < 50);
    if (!got) chk("byte_accept_timeout", 0, 1);
    BYTE_VALID = 1'b0;
    BYTE_IN    = 8'($urandom);
  endtask

  task automatic run_load(input int n, input int gapmax, input bit bad_chk);
    logic [7:0]  bytes[$];
    logic [15:0] w;
    logic [7:0]  x;
    bit          exp_err;
    bit          hdr_err;
    hdr_err = (n > 4096);
    exp_err = hdr_err;
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    if (!hdr_err) begin
      for (int i = 0; i < n; i++) begin
        w = (img.size() > 0) ? img.pop_front() : 16'($urandom);
        bytes.push_back(w[15:8]);
        bytes.push_back(w[7:0]);
        q_exp.push_back({12'(i), w});
      end
      if (CHK_EN) begin
        x = '0;
        foreach (bytes[i]) x ^= bytes[i];
        bytes.push_back(bad_chk ? (x ^ 8'h01) : x);
        exp_err = bad_chk;
      end
    end
    img.delete();
    full_image = !hdr_err;
    pulse_start();
    chk("busy_after_start", LOAD_BUSY, 1);
    chk("done_cleared", LOAD_DONE, 0);
    chk("err_cleared", LOAD_ERROR, 0);
    foreach (bytes[i]) send_byte(bytes[i], gapmax);
    repeat (3) @(posedge clk);
    #1;
    chk("writes_pending", q_exp.size(), 0);
    q_exp.delete();
    chk("load_done", LOAD_DONE, !exp_err);
    chk("load_error", LOAD_ERROR, exp_err);
    chk("load_busy_end", LOAD_BUSY, 0);
    chk("ready_end", BYTE_READY, 0);
    chk("words_loaded", WORDS_LOADED, hdr_err ? 0 : n);
  endtask

  initial begin
    logic [15:0] w0, w1;
    full_image = 1'b0;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", BYTE_READY, 0);
    chk("rst_wr_en", MEM_WR_EN, 0);
    chk("rst_wr_addr", MEM_WR_ADDR, 0);
    chk("rst_wr_data", MEM_WR_DATA, 0);
    chk("rst_busy", LOAD_BUSY, 0);
    chk("rst_done", LOAD_DONE, 0);
    chk("rst_error", LOAD_ERROR, 0);
    chk("rst_words", WORDS_LOADED, 0);
    rst = 1'b0;
    BYTE_VALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", BYTE_READY, 0);
    chk("idle_words", WORDS_LOADED, 0);
    BYTE_VALID = 1'b0;

    // Nominal image, back-to-back then with gaps
    img = '{16'h6401, 16'h5300};
    run_load(2, 0, 0);
    chk("nom_words_lit", WORDS_LOADED, 2);
    img = '{16'h6401, 16'h5300};
    run_load(2, 2, 0);

    // Header boundaries and restart from ERR
    run_load(0, 0, 0);
    run_load(4097, 1, 0);
    chk("err_lit", LOAD_ERROR, 1);
    run_load(5, 1, 0);
    run_load(4096, 0, 0);

    // Randomized loads
    for (int k = 0; k < 12; k++)
      run_load($urandom_range(1, 40), $urandom_range(0, 3), CHK_EN ? 1'($urandom) : 1'b0);

    if (CHK_EN) begin
      img = '{16'h6401};
      run_load(1, 0, 0);
      img = '{16'h6401};
      run_load(1, 0, 1);
    end

    // Reset between instr and arg of word 1
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    full_image = 1'b0;
    q_exp.push_back({12'd0, w0});
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(w0[15:8], 0);
    send_byte(w0[7:0], 0);
    send_byte(w1[15:8], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr_en", MEM_WR_EN, 0);
    chk("midrst_busy", LOAD_BUSY, 0);
    chk("midrst_ready", BYTE_READY, 0);
    chk("midrst_words", WORDS_LOADED, 0);
    chk("midrst_writes", q_exp.size(), 0);
    rst = 1'b0;
    BYTE_VALID = 1'b1;
    BYTE_IN = w1[7:0];
    repeat (2) @(posedge clk);
    #1;
    BYTE_VALID = 1'b0;
    chk("midrst_idle_ready", BYTE_READY, 0);
    run_load(3, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
